// File: rtl/serial_adder_arbiter.sv
// -----------------------------------------------------------------------------
// serial_adder_arbiter
//
// Purpose:
//   Two operand producers share one full-adder cell. A round-robin arbiter
//   grants one requester at a time. The granted operand pair is summed bit
//   serially, LSB first, one bit per clock, with a registered carry. The
//   result is then held in an output register until the consumer takes it.
//   This trades WIDTH+2 cycles of latency for the area of a single full adder.
//
// Optional feature:
//   `SERIAL_ADDER_SUB_EN  adds iSub0/iSub1. When the granted iSub is 1 the
//   block computes A-B modulo 2^WIDTH. oCarryOut=1 then means "no borrow".
//   When the macro is undefined the ports are absent and the block only adds.
//
// Parameters:
//   WIDTH        operand/result width in bits (>= 2)
//
// Ports:
//   iClk         clock, rising edge
//   iRst         asynchronous active-high reset
//   iReqValid0/1 requester N has an operand pair
//   iOpA0/1      operand A of requester N
//   iOpB0/1      operand B of requester N
//   iSub0/1      subtract select of requester N (only with SERIAL_ADDER_SUB_EN)
//   oReqReady0/1 grant (combinational; high only in IDLE, for the winner)
//   oResValid    result register holds a valid result
//   iResReady    consumer accepts the result when oResValid is high
//   oResult      WIDTH-bit sum (or difference)
//   oCarryOut    carry out of bit WIDTH-1
//   oResId       index of the requester that owns the result
// -----------------------------------------------------------------------------
module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iReqValid0,
    input  logic             iReqValid1,
    input  logic [WIDTH-1:0] iOpA0,
    input  logic [WIDTH-1:0] iOpA1,
    input  logic [WIDTH-1:0] iOpB0,
    input  logic [WIDTH-1:0] iOpB1,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             iSub0,
    input  logic             iSub1,
`endif
    output logic             oReqReady0,
    output logic             oReqReady1,
    output logic             oResValid,
    input  logic             iResReady,
    output logic [WIDTH-1:0] oResult,
    output logic             oCarryOut,
    output logic             oResId
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The single shared adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
        logic s;
        logic c;
        s = a ^ b ^ cin;
        c = (a & b) | (a & cin) | (b & cin);
        return {c, s};
    endfunction

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             last_id;   // requester served most recently

    logic             win_id;
    logic             accept;
    logic             carry_init;
    logic             b_bit;
    logic             sum_bit;
    logic             cout_bit;
    logic             last_shift;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;
    logic win_sub;
    assign win_sub    = win_id ? iSub1 : iSub0;
    // Two's-complement subtract: invert B and start with carry-in 1.
    assign carry_init = win_sub;
`else
    logic sub_q;
    assign sub_q      = 1'b0;
    assign carry_init = 1'b0;
`endif

    // Round-robin: with both valid, the one not served last wins. last_id
    // resets to 1 so requester 0 has priority straight out of reset.
    always_comb begin
        win_id = 1'b0;
        if (iReqValid0 && iReqValid1) begin
            win_id = ~last_id;
        end else if (iReqValid1) begin
            win_id = 1'b1;
        end
    end

    assign oReqReady0 = (state == IDLE) && iReqValid0 && !win_id;
    assign oReqReady1 = (state == IDLE) && iReqValid1 &&  win_id;
    assign accept     = oReqReady0 || oReqReady1;

    assign b_bit                = b_sh[0] ^ sub_q;
    assign {cout_bit, sum_bit}  = full_adder(a_sh[0], b_bit, carry_q);
    assign last_shift           = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            last_id   <= 1'b1;
            oResValid <= 1'b0;
            oResult   <= '0;
            oCarryOut <= 1'b0;
            oResId    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= win_id ? iOpA1 : iOpA0;
                        b_sh    <= win_id ? iOpB1 : iOpB0;
                        carry_q <= carry_init;
                        cnt     <= '0;
                        oResId  <= win_id;
                        last_id <= win_id;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q   <= win_sub;
`endif
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Sum bits enter from the MSB side so that after WIDTH
                    // shifts the first (LSB) sum bit sits at bit 0.
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= {sum_bit, res_sh[WIDTH-1:1]};
                    carry_q <= cout_bit;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        oResult   <= {sum_bit, res_sh[WIDTH-1:1]};
                        oCarryOut <= cout_bit;
                        oResValid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (iResReady) begin
                        oResValid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_arbiter
//
// Self-checking bench for serial_adder_arbiter (WIDTH=8). The reference model
// is plain arithmetic on integers plus a "last served" variable for the
// round-robin rule. Stimulus is driven and outputs sampled 1 time unit after
// the rising clock edge.
// -----------------------------------------------------------------------------
module tb_serial_adder_arbiter;

    localparam int W = 8;

    logic         iClk;
    logic         iRst;
    logic         iReqValid0;
    logic         iReqValid1;
    logic [W-1:0] iOpA0;
    logic [W-1:0] iOpA1;
    logic [W-1:0] iOpB0;
    logic [W-1:0] iOpB1;
    logic         oReqReady0;
    logic         oReqReady1;
    logic         oResValid;
    logic         iResReady;
    logic [W-1:0] oResult;
    logic         oCarryOut;
    logic         oResId;
`ifdef SERIAL_ADDER_SUB_EN
    logic         iSub0;
    logic         iSub1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic model_last;   // requester served most recently (reference model)

    serial_adder_arbiter #(.WIDTH(W)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iReqValid0 (iReqValid0),
        .iReqValid1 (iReqValid1),
        .iOpA0      (iOpA0),
        .iOpA1      (iOpA1),
        .iOpB0      (iOpB0),
        .iOpB1      (iOpB1),
`ifdef SERIAL_ADDER_SUB_EN
        .iSub0      (iSub0),
        .iSub1      (iSub1),
`endif
        .oReqReady0 (oReqReady0),
        .oReqReady1 (oReqReady1),
        .oResValid  (oResValid),
        .iResReady  (iResReady),
        .oResult    (oResult),
        .oCarryOut  (oCarryOut),
        .oResId     (oResId)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // Reference winner from the round-robin rule.
    function automatic logic model_winner(input logic v0, input logic v1);
        if (v0 && v1) return !model_last;
        return v1;
    endfunction

    // Reference sum: {carry, result}. Subtract: result = A-B mod 2^W, carry = no borrow.
    function automatic logic [W:0] model_calc(input int unsigned a, input int unsigned b, input bit sub);
        int unsigned r;
        if (sub) begin
            r = (a - b) & ((1 << W) - 1);
            return {logic'(a >= b), r[W-1:0]};
        end
        r = a + b;
        return r[W:0];
    endfunction

    // Drives one request, waits (bounded) for the grant, waits for the result,
    // then acknowledges it. Returns what was observed; callers do the checks.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input bit keep,
                           output logic win, output logic [W-1:0] res,
                           output logic co, output logic rid,
                           output int lat, output bit tmo, output bit excl_bad);
        int n;
        tmo = 0; excl_bad = 0; lat = 0; win = 0; res = '0; co = 0; rid = 0;
        iReqValid0 = v0; iReqValid1 = v1;
        iOpA0 = a0; iOpB0 = b0; iOpA1 = a1; iOpB1 = b1;
        #1;
        n = 0;
        while (!(oReqReady0 || oReqReady1) && n < 20) begin
            if (oReqReady0 && oReqReady1) excl_bad = 1;
            @(posedge iClk); #1;
            n++;
        end
        if (oReqReady0 && oReqReady1) excl_bad = 1;
        if (!(oReqReady0 || oReqReady1)) begin
            tmo = 1;
            iReqValid0 = 0; iReqValid1 = 0;
            return;
        end
        win = oReqReady1;
        @(posedge iClk); #1;
        if (!keep) begin
            iReqValid0 = 0; iReqValid1 = 0;
        end
        while (!oResValid && lat < 4 * W) begin
            if (oReqReady0 || oReqReady1) excl_bad = 1;
            @(posedge iClk); #1;
            lat++;
        end
        if (!oResValid) begin
            tmo = 1;
            return;
        end
        res = oResult; co = oCarryOut; rid = oResId;
        iResReady = 1;
        @(posedge iClk); #1;
        iResReady = 0;
    endtask

    task automatic test_reset();
        iRst = 1; iReqValid0 = 0; iReqValid1 = 0; iResReady = 0;
        iOpA0 = '0; iOpA1 = '0; iOpB0 = '0; iOpB1 = '0;
`ifdef SERIAL_ADDER_SUB_EN
        iSub0 = 0; iSub1 = 0;
`endif
        repeat (3) @(posedge iClk);
        #1 iRst = 0;
        model_last = 1'b1;
        #1;
        n_tests++;
        if ({oResValid, oResult, oCarryOut, oResId, oReqReady0, oReqReady1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b res=%h co=%b id=%b rdy=%b%b, want all 0",
                     oResValid, oResult, oCarryOut, oResId, oReqReady0, oReqReady1);
        end
        iReqValid0 = 1; iReqValid1 = 1;
        #1;
        n_tests++;
        if ({oReqReady0, oReqReady1} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_priority: got rdy0/rdy1=%b%b, want 10", oReqReady0, oReqReady1);
        end
        iReqValid0 = 0; iReqValid1 = 0;
        @(posedge iClk); #1;
    endtask

    task automatic test_arbitration();
        logic win, co, rid; logic [W-1:0] res; int lat; bit tmo, ex;
        logic exp_id;
        for (int i = 0; i < 4; i++) begin
            exp_id = model_winner(1, 1);
            run_txn(1, 1, 8'(i), 8'(i + 1), 8'(i + 10), 8'(i + 20), 1, win, res, co, rid, lat, tmo, ex);
            model_last = exp_id;
            n_tests++;
            if (tmo || win !== exp_id || rid !== exp_id || ex) begin
                n_fail++;
                $display("FAIL arb_both_%0d: got grant=%b id=%b tmo=%b both_ready=%b, want grant=%b id=%b",
                         i, win, rid, tmo, ex, exp_id, exp_id);
            end
            n_tests++;
            if (res !== (exp_id ? 8'(2 * i + 30) : 8'(2 * i + 1))) begin
                n_fail++;
                $display("FAIL arb_sum_%0d: got %h", i, res);
            end
        end
        iReqValid0 = 0; iReqValid1 = 0;
    endtask

    task automatic test_single_add();
        logic win, co, rid; logic [W-1:0] res; int lat; bit tmo, ex;
        run_txn(1, 0, 8'h5A, 8'h33, 8'h00, 8'h00, 0, win, res, co, rid, lat, tmo, ex);
        model_last = 0;
        n_tests++;
        if (tmo || res !== 8'h8D || co !== 1'b0 || rid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_add: got res=%h co=%b id=%b tmo=%b, want res=8d co=0 id=0", res, co, rid, tmo);
        end
        n_tests++;
        if (lat !== W) begin
            n_fail++;
            $display("FAIL single_latency: got %0d edges, want %0d", lat, W);
        end
    endtask

    task automatic test_wrap();
        logic win, co, rid; logic [W-1:0] res; int lat; bit tmo, ex;
        run_txn(0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 0, win, res, co, rid, lat, tmo, ex);
        model_last = 1;
        n_tests++;
        if (tmo || win !== 1'b1 || res !== 8'h00 || co !== 1'b1 || rid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_ff_01: got grant=%b res=%h co=%b id=%b tmo=%b, want 1 00 1 1", win, res, co, rid, tmo);
        end
        run_txn(0, 1, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, win, res, co, rid, lat, tmo, ex);
        n_tests++;
        if (tmo || win !== 1'b1 || res !== 8'hFE || co !== 1'b1 || rid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_ff_ff: got grant=%b res=%h co=%b id=%b tmo=%b, want 1 fe 1 1", win, res, co, rid, tmo);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_res; logic held_co, held_id;
        int n;
        bit bad;
        iReqValid0 = 1; iOpA0 = 8'h3C; iOpB0 = 8'h0F; iReqValid1 = 0;
        #1;
        n_tests++;
        if (!oReqReady0) begin
            n_fail++;
            $display("FAIL bp_grant: got rdy0=%b, want 1", oReqReady0);
        end
        @(posedge iClk); #1;
        model_last = 0;
        iReqValid1 = 1; iOpA1 = 8'h77; iOpB1 = 8'h11;   // keep both asking during DONE
        n = 0;
        while (!oResValid && n < 4 * W) begin
            @(posedge iClk); #1; n++;
        end
        held_res = oResult; held_co = oCarryOut; held_id = oResId;
        n_tests++;
        if (!oResValid || held_res !== 8'h4B || held_co !== 1'b0 || held_id !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: got valid=%b res=%h co=%b id=%b, want 1 4b 0 0", oResValid, held_res, held_co, held_id);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge iClk); #1;
            if (!oResValid || oResult !== held_res || oCarryOut !== held_co || oResId !== held_id
                || oReqReady0 || oReqReady1) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: got valid=%b res=%h rdy=%b%b, want held result and no ready",
                     oResValid, oResult, oReqReady0, oReqReady1);
        end
        iResReady = 1;
        @(posedge iClk); #1;
        iResReady = 0;
        n_tests++;
        // Back in IDLE: both valid, last served was 0, so requester 1 is granted.
        if (oResValid !== 1'b0 || {oReqReady0, oReqReady1} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b rdy=%b%b, want valid=0 rdy=01", oResValid, oReqReady0, oReqReady1);
        end
        iReqValid0 = 0; iReqValid1 = 0;
        @(posedge iClk); #1;
    endtask

    task automatic test_reset_mid();
        logic win, co, rid; logic [W-1:0] res; int lat; bit tmo, ex;
        bit seen;
        iReqValid1 = 1; iOpA1 = 8'hAA; iOpB1 = 8'h55;
        #1;
        @(posedge iClk); #1;    // accept edge
        iReqValid1 = 0;
        @(posedge iClk); #1;    // shift 1
        @(posedge iClk); #1;    // shift 2, now in the 3rd shift cycle
        iRst = 1;
        #1;
        n_tests++;
        if ({oResValid, oResult, oCarryOut, oResId, oReqReady0, oReqReady1} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid=%b res=%h co=%b id=%b rdy=%b%b, want all 0",
                     oResValid, oResult, oCarryOut, oResId, oReqReady0, oReqReady1);
        end
        @(posedge iClk); #1;
        iRst = 0;
        model_last = 1;
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge iClk); #1;
            if (oResValid) seen = 1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset_spurious: got oResValid=1 after abort, want 0");
        end
        run_txn(1, 0, 8'h10, 8'h20, 8'h00, 8'h00, 0, win, res, co, rid, lat, tmo, ex);
        model_last = 0;
        n_tests++;
        if (tmo || res !== 8'h30 || co !== 1'b0 || rid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_reissue: got res=%h co=%b id=%b tmo=%b, want 30 0 0", res, co, rid, tmo);
        end
    endtask

    task automatic test_random();
        logic win, co, rid; logic [W-1:0] res; int lat; bit tmo, ex;
        logic v0, v1, exp_id;
        logic [W-1:0] a0, b0, a1, b1;
        logic [W:0] exp;
        for (int i = 0; i < 24; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            exp_id = model_winner(v0, v1);
            exp = exp_id ? model_calc(a1, b1, 0) : model_calc(a0, b0, 0);
            run_txn(v0, v1, a0, b0, a1, b1, 0, win, res, co, rid, lat, tmo, ex);
            model_last = exp_id;
            n_tests++;
            if (tmo || ex || win !== exp_id || rid !== exp_id || {co, res} !== exp || lat !== W) begin
                n_fail++;
                $display("FAIL random_%0d: got grant=%b id=%b co=%b res=%h lat=%0d tmo=%b both_ready=%b, want grant=%b co=%b res=%h lat=%0d",
                         i, win, rid, co, res, lat, tmo, ex, exp_id, exp[W], exp[W-1:0], W);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic win, co, rid; logic [W-1:0] res; int lat; bit tmo, ex;
        logic [W:0] exp;
        iSub0 = 1; iSub1 = 0;
        run_txn(1, 0, 8'h10, 8'h01, 8'h00, 8'h00, 0, win, res, co, rid, lat, tmo, ex);
        exp = model_calc(8'h10, 8'h01, 1);
        n_tests++;
        if (tmo || {co, res} !== exp || {co, res} !== 9'h10F) begin
            n_fail++;
            $display("FAIL sub_10_01: got co=%b res=%h, want 1 0f", co, res);
        end
        run_txn(1, 0, 8'h01, 8'h02, 8'h00, 8'h00, 0, win, res, co, rid, lat, tmo, ex);
        n_tests++;
        if (tmo || {co, res} !== 9'h0FF) begin
            n_fail++;
            $display("FAIL sub_01_02: got co=%b res=%h, want 0 ff", co, res);
        end
        iSub0 = 0;
        run_txn(1, 0, 8'hC8, 8'h64, 8'h00, 8'h00, 0, win, res, co, rid, lat, tmo, ex);
        n_tests++;
        if (tmo || {co, res} !== 9'h12C) begin
            n_fail++;
            $display("FAIL sub_off_add: got co=%b res=%h, want 1 2c", co, res);
        end
        model_last = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_arbitration();
        test_single_add();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_arbiter.md
# serial_adder_arbiter

Shares one `full_adder` cell between two requesters and runs it as a bit-serial adder: one bit per clock, LSB first, with a registered carry. A round-robin arbiter grants one requester at a time. The granted operand pair is summed over WIDTH cycles, and the result is held in an output register until the consumer accepts it. The block sits between operand producers and a consumer, trading latency for area against a parallel adder.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  reset, asynchronous and active-high.
- iReqValid0 / iReqValid1  input  1  requester 0 / 1 has an operand pair.
- iOpA0 / iOpA1  input  WIDTH  operand A of requester 0 / 1.
- iOpB0 / iOpB1  input  WIDTH  operand B of requester 0 / 1.
- oReqReady0 / oReqReady1  output  1  grant. The transfer happens on the edge where valid and ready are both high.
- oResValid  output  1  result register holds a valid result.
- iResReady  input  1  consumer accepts the result on the edge where oResValid and iResReady are both high.
- oResult  output  WIDTH  sum.
- oCarryOut  output  1  carry out of the MSB.
- oResId  output  1  index of the requester that owns the result.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - Arbiter selects among valid requesters.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not served last wins.
  - After reset, requester 0 has priority.
  - oReqReadyN is combinational: high only in IDLE for the winner. The loser's ready stays 0.
- **Accept**
  - Load the winner's A and B into shift registers.
  - Clear the carry register (set it to 1 for a subtract, see Configuration).
  - Latch the requester index, update the round-robin pointer, clear the bit counter, go to SHIFT.
- **SHIFT**
  - The single full_adder takes the A LSB, the B LSB and the carry register.
  - Its sum bit shifts into the result register from the MSB side.
  - Its carry-out goes into the carry register.
  - The A and B registers shift right and the counter increments.
  - After WIDTH SHIFT cycles, go to DONE.
- **DONE**
  - oResValid=1.
  - oResult, oCarryOut and oResId are stable.
  - On iResReady, go to IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. oCarryOut is the true carry out of bit WIDTH-1.
- Requesters must hold valid and operands stable until ready. The block does not sample operands outside the accept edge.
- A valid that drops before it is granted is ignored; nothing is queued.

## Timing
- Reset values:
  - state IDLE, with the round-robin pointer set so that requester 0 wins.
  - oResValid 0, oResult 0, oCarryOut 0, oResId 0.
  - Internal shift, carry and counter registers 0.
  - oReqReadyN follows IDLE logic immediately after reset deasserts.
- Latency: if accept is on edge k, oResValid rises after edge k+WIDTH.
- Minimum issue interval: WIDTH+2 cycles (accept, WIDTH shifts, and one DONE cycle when iResReady=1).
- Back-to-back: the earliest next accept is the edge after the DONE handshake edge, because ready is high only in IDLE.
- iResReady low in DONE: hold all outputs; both readies stay 0 indefinitely.
- Reset mid-operation (SHIFT or DONE): the transaction is aborted and no result is produced. The requester must re-issue.
- Counter width: $clog2(WIDTH+1).

## Configuration
- Macro `SERIAL_ADDER_SUB_EN`.
- **Defined:**
  - Adds ports iSub0 and iSub1 (input, 1 bit), sampled with the operands at accept.
  - When the granted iSub is 1, the B bit fed to the adder is inverted and the carry register initialises to 1, giving A-B modulo 2^WIDTH.
  - oCarryOut=1 means no borrow.
- **Undefined:** the ports are absent and the block always adds with carry-in 0.

## Test plan
- Single add (WIDTH=8): req0 A=0x5A, B=0x33 → oResult=0x8D, oCarryOut=0, oResId=0. oResValid is high exactly 8 edges after the accept edge.
- Wrap: req1 A=0xFF, B=0x01 → oResult=0x00, oCarryOut=1, oResId=1. Also 0xFF+0xFF → 0xFE, carry 1.
- Arbitration:
  - Both valid from reset → grants in order 0,1,0,1 with both held valid.
  - Only req1 valid twice → it is granted both times.
  - oReqReady0 and oReqReady1 are never high together.
- Backpressure: iResReady=0 for 5 cycles in DONE → outputs constant, both readies 0, no accept. Then iResReady=1 → IDLE next edge.
- Reset at the 3rd SHIFT cycle → all outputs return to reset values at once, with no spurious oResValid. A re-issued 0x10+0x20 gives 0x30.
- With `SERIAL_ADDER_SUB_EN`: 0x10-0x01 → 0x0F, carry 1; 0x01-0x02 → 0xFF, carry 0; add with iSub=0 is unchanged.
